// File: rtl/icache_pkg.sv
// Shared I-cache definitions: refill FSM states, address-geometry helpers and
// address field extraction used by both the refill controller and the lookup path.
// Extract functions work on a 64-bit container; callers cast the result to their field width.
package icache_pkg;

  typedef enum logic [2:0] {
    FLUSH    = 3'd0,
    IDLE     = 3'd1,
    MEM_REQ  = 3'd2,
    MEM_RECV = 3'd3,
    WRITE    = 3'd4
  } refill_state_e;

  function automatic int icache_off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int icache_bank_w(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int icache_tag_width(input int addr_width, input int line_bytes,
                                          input int num_banks, input int set_w);
    return addr_width - icache_off_w(line_bytes) - icache_bank_w(num_banks) - set_w;
  endfunction

  // Address layout, MSB to LSB: {tag, set, bank, offset}
  function automatic logic [63:0] icache_addr_bank(input logic [63:0] addr, input int off_w,
                                                   input int bank_w);
    return (addr >> off_w) & ((64'd1 << bank_w) - 64'd1);
  endfunction

  function automatic logic [63:0] icache_addr_set(input logic [63:0] addr, input int off_w,
                                                  input int bank_w, input int set_w);
    return (addr >> (off_w + bank_w)) & ((64'd1 << set_w) - 64'd1);
  endfunction

  function automatic logic [63:0] icache_addr_tag(input logic [63:0] addr, input int off_w,
                                                  input int bank_w, input int set_w);
    return addr >> (off_w + bank_w + set_w);
  endfunction

  function automatic logic [63:0] icache_line_base(input logic [63:0] addr, input int off_w);
    return addr & ~((64'd1 << off_w) - 64'd1);
  endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way selector for I-cache refills.
// Latency: way_o is registered; it moves to the next victim the cycle after advance_i.
// Backpressure: none; advance_i is a single-cycle strobe from the refill write cycle.
// Ports: clk_i/rst_i (sync, active-high), advance_i (step the selector), way_o (current victim).
// Build option ICACHE_LFSR_VICTIM_EN: pseudo-random victim from an 8-bit LFSR
// (x^8+x^6+x^5+x^4+1, seed 8'h01); otherwise a round-robin pointer.
module icache_victim_sel #(
  parameter int NUM_WAYS = 4,
  localparam int WAY_W   = $clog2(NUM_WAYS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             advance_i,
  output logic [WAY_W-1:0] way_o
);

`ifdef ICACHE_LFSR_VICTIM_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci form: taps at bits 8,6,5,4 (1-based) shift into the LSB.
  always_comb begin
    lfsr_d = lfsr_q;
    if (advance_i) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign way_o = lfsr_q[WAY_W-1:0];
`else
  logic [WAY_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (ptr_q == WAY_W'(NUM_WAYS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign way_o = ptr_q;
`endif

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache refill/invalidate controller: owns tag+data array writes, one miss at a time.
// Latency: miss accepted at T -> mem request at T+1; last beat at L -> array write at L+1, ready at L+2.
// Backpressure: miss_ready_o low outside IDLE or while a flush is requested; mem request held until ready.
// Ports: miss_* (fetch miss handshake), flush_i/flush_busy_o (full invalidate), mem_req_*/mem_rsp_*
//   (line fetch, response has no backpressure), tag_w_*/tag_we*/tag_wdata_* and data_we*/data_wdata_o
//   (array write ports), refill_done_o/refill_way_o (write-cycle pulse and chosen way).
// Build option ICACHE_LFSR_VICTIM_EN: selects the LFSR victim policy in icache_victim_sel.
module icache_refill_ctrl
  import icache_pkg::*;
#(
  parameter int NUM_WAYS            = 4,
  parameter int NUM_BANKS           = 4,
  parameter int SETS_PER_BANK_WIDTH = 8,
  parameter int ADDR_WIDTH          = 32,
  parameter int LINE_BYTES          = 16,
  parameter int MEM_DATA_WIDTH      = 64,
  localparam int OFF_W     = icache_off_w(LINE_BYTES),
  localparam int BANK_W    = icache_bank_w(NUM_BANKS),
  localparam int TAG_WIDTH = icache_tag_width(ADDR_WIDTH, LINE_BYTES, NUM_BANKS, SETS_PER_BANK_WIDTH),
  localparam int WAY_W     = $clog2(NUM_WAYS),
  localparam int LINE_W    = LINE_BYTES * 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           miss_valid_i,
  output logic                           miss_ready_o,
  input  logic [ADDR_WIDTH-1:0]          miss_addr_i,
  input  logic                           flush_i,
  output logic                           flush_busy_o,
  output logic                           mem_req_valid_o,
  input  logic                           mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]          mem_req_addr_o,
  input  logic                           mem_rsp_valid_i,
  input  logic [MEM_DATA_WIDTH-1:0]      mem_rsp_data_i,
  output logic [SETS_PER_BANK_WIDTH-1:0] tag_w_bank_addr_o,
  output logic [BANK_W-1:0]              tag_w_bank_sel_o,
  output logic [NUM_WAYS-1:0]            tag_we_way_mask_o,
  output logic [TAG_WIDTH-1:0]           tag_wdata_tag_o,
  output logic                           tag_wdata_valid_o,
  output logic [NUM_WAYS-1:0]            data_we_way_mask_o,
  output logic [LINE_W-1:0]              data_wdata_o,
  output logic                           refill_done_o,
  output logic [WAY_W-1:0]               refill_way_o
);

  localparam int BEATS  = LINE_W / MEM_DATA_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W  = SETS_PER_BANK_WIDTH + BANK_W;

  refill_state_e             state_q, state_d;
  logic [CNT_W-1:0]          flush_cnt_q, flush_cnt_d;
  logic                      flush_pend_q, flush_pend_d;
  logic [BEAT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic [WAY_W-1:0]          victim_way;
  logic                      victim_adv;

  // Fields of the latched miss address, as seen by the arrays.
  logic [SETS_PER_BANK_WIDTH-1:0] miss_set;
  logic [BANK_W-1:0]              miss_bank;
  logic [TAG_WIDTH-1:0]           miss_tag;
  logic [ADDR_WIDTH-1:0]          miss_line_addr;

  assign miss_set  = SETS_PER_BANK_WIDTH'(icache_addr_set(64'(addr_q), OFF_W, BANK_W,
                                                          SETS_PER_BANK_WIDTH));
  assign miss_bank = BANK_W'(icache_addr_bank(64'(addr_q), OFF_W, BANK_W));
  assign miss_tag  = TAG_WIDTH'(icache_addr_tag(64'(addr_q), OFF_W, BANK_W, SETS_PER_BANK_WIDTH));
  assign miss_line_addr = ADDR_WIDTH'(icache_line_base(64'(addr_q), OFF_W));

  assign victim_adv = refill_done_o;

  icache_victim_sel #(
    .NUM_WAYS (NUM_WAYS)
  ) u_victim_sel (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .advance_i (victim_adv),
    .way_o     (victim_way)
  );

  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    flush_pend_d = flush_pend_q;
    beat_cnt_d   = beat_cnt_q;
    addr_d       = addr_q;
    line_d       = line_q;

    miss_ready_o       = 1'b0;
    flush_busy_o       = (state_q == FLUSH);
    mem_req_valid_o    = 1'b0;
    mem_req_addr_o     = '0;
    tag_w_bank_addr_o  = '0;
    tag_w_bank_sel_o   = '0;
    tag_we_way_mask_o  = '0;
    tag_wdata_tag_o    = '0;
    tag_wdata_valid_o  = 1'b0;
    data_we_way_mask_o = '0;
    data_wdata_o       = line_q;
    refill_done_o      = 1'b0;
    refill_way_o       = '0;

    case (state_q)
      FLUSH: begin
        // Sweep counter is {set, bank}; invalidate that entry in every way.
        tag_we_way_mask_o = '1;
        tag_w_bank_sel_o  = flush_cnt_q[BANK_W-1:0];
        tag_w_bank_addr_o = flush_cnt_q[CNT_W-1:BANK_W];
        flush_cnt_d       = flush_cnt_q + CNT_W'(1);
        if (flush_cnt_q == {CNT_W{1'b1}}) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        miss_ready_o = ~flush_i & ~flush_pend_q;
        if (flush_i || flush_pend_q) begin
          state_d = FLUSH;
        end else if (miss_valid_i) begin
          addr_d  = miss_addr_i;
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = miss_line_addr;
        if (mem_req_ready_i) begin
          beat_cnt_d = '0;
          state_d    = MEM_RECV;
        end
      end
      MEM_RECV: begin
        if (mem_rsp_valid_i) begin
          line_d[beat_cnt_q*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = mem_rsp_data_i;
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        tag_we_way_mask_o  = NUM_WAYS'(1) << victim_way;
        data_we_way_mask_o = NUM_WAYS'(1) << victim_way;
        tag_w_bank_sel_o   = miss_bank;
        tag_w_bank_addr_o  = miss_set;
        tag_wdata_tag_o    = miss_tag;
        tag_wdata_valid_o  = 1'b1;
        refill_done_o      = 1'b1;
        refill_way_o       = victim_way;
        state_d            = flush_pend_q ? FLUSH : IDLE;
      end
      default: begin
        state_d = FLUSH;
      end
    endcase

    // A flush that arrives mid-refill waits for the line write to finish.
    if (flush_i && (state_q == MEM_REQ || state_q == MEM_RECV || state_q == WRITE)) begin
      flush_pend_d = 1'b1;
    end
    if (state_d == FLUSH && state_q != FLUSH) begin
      flush_pend_d = 1'b0;
      flush_cnt_d  = '0;
    end

    // Outputs are quiet during reset regardless of the stale state register,
    // except flush_busy_o which already reflects the sweep that reset will start.
    if (rst_i) begin
      miss_ready_o       = 1'b0;
      flush_busy_o       = 1'b1;
      mem_req_valid_o    = 1'b0;
      mem_req_addr_o     = '0;
      tag_w_bank_addr_o  = '0;
      tag_w_bank_sel_o   = '0;
      tag_we_way_mask_o  = '0;
      tag_wdata_tag_o    = '0;
      tag_wdata_valid_o  = 1'b0;
      data_we_way_mask_o = '0;
      data_wdata_o       = '0;
      refill_done_o      = 1'b0;
      refill_way_o       = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= FLUSH;
      flush_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_pend_q <= flush_pend_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Address and line buffers are only consumed in states reached after a fresh
  // miss handshake and full beat sequence, so they need no reset.
  always_ff @(posedge clk_i) begin
    addr_q <= addr_d;
    line_q <= line_d;
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         miss_valid_i;
  logic         miss_ready_o;
  logic [31:0]  miss_addr_i;
  logic         flush_i;
  logic         flush_busy_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i;
  logic [63:0]  mem_rsp_data_i;
  logic [7:0]   tag_w_bank_addr_o;
  logic [1:0]   tag_w_bank_sel_o;
  logic [3:0]   tag_we_way_mask_o;
  logic [17:0]  tag_wdata_tag_o;
  logic         tag_wdata_valid_o;
  logic [3:0]   data_we_way_mask_o;
  logic [127:0] data_wdata_o;
  logic         refill_done_o;
  logic [1:0]   refill_way_o;

  icache_refill_ctrl dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .miss_valid_i       (miss_valid_i),
    .miss_ready_o       (miss_ready_o),
    .miss_addr_i        (miss_addr_i),
    .flush_i            (flush_i),
    .flush_busy_o       (flush_busy_o),
    .mem_req_valid_o    (mem_req_valid_o),
    .mem_req_ready_i    (mem_req_ready_i),
    .mem_req_addr_o     (mem_req_addr_o),
    .mem_rsp_valid_i    (mem_rsp_valid_i),
    .mem_rsp_data_i     (mem_rsp_data_i),
    .tag_w_bank_addr_o  (tag_w_bank_addr_o),
    .tag_w_bank_sel_o   (tag_w_bank_sel_o),
    .tag_we_way_mask_o  (tag_we_way_mask_o),
    .tag_wdata_tag_o    (tag_wdata_tag_o),
    .tag_wdata_valid_o  (tag_wdata_valid_o),
    .data_we_way_mask_o (data_we_way_mask_o),
    .data_wdata_o       (data_wdata_o),
    .refill_done_o      (refill_done_o),
    .refill_way_o       (refill_way_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference victim sequence: round-robin, or the 8-bit LFSR from seed 8'h01.
  logic [7:0] lfsr_m;
  logic [1:0] rr_m;

  task automatic model_reset();
    lfsr_m = 8'h01;
    rr_m   = 2'd0;
  endtask

  function automatic logic [1:0] model_way();
`ifdef ICACHE_LFSR_VICTIM_EN
    return lfsr_m[1:0];
`else
    return rr_m;
`endif
  endfunction

  task automatic model_advance();
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    rr_m   = rr_m + 2'd1;
  endtask

  // Counts cycles with flush_busy_o high starting at the current sample point;
  // also counts any data write or refill pulse seen during the sweep.
  int spurious;
  task automatic wait_sweep(output int n);
    n = 0;
    while (flush_busy_o && n < 1200) begin
      if (refill_done_o || data_we_way_mask_o != 4'h0 || mem_req_valid_o) spurious++;
      n++;
      @(negedge clk_i); #1;
    end
  endtask

  task automatic refill(input string nm, input logic [31:0] addr, input logic [31:0] exp_al,
                        input logic [1:0] exp_bank, input logic [7:0] exp_set,
                        input logic [17:0] exp_tag, input logic [63:0] b0, input logic [63:0] b1,
                        input int dly, input bit do_flush);
    int nv;
    int early_wr;
    logic [1:0] w;
    logic [3:0] m;
    w = model_way();
    m = 4'b0001 << w;
    nv = 0;
    early_wr = 0;
    @(negedge clk_i); miss_valid_i = 1'b1; miss_addr_i = addr; #1;
    check({nv_s(nm), "_miss_ready"}, miss_ready_o, 1);
    @(negedge clk_i); miss_valid_i = 1'b0; miss_addr_i = '0; #1;
    check({nv_s(nm), "_req_addr"}, mem_req_addr_o, exp_al);
    for (int i = 0; i <= dly; i++) begin
      if (i > 0) begin
        @(negedge clk_i); #1;
      end
      mem_req_ready_i = (i == dly);
      #1;
      if (mem_req_valid_o && mem_req_addr_o == exp_al) nv++;
      if (tag_we_way_mask_o != 4'h0 || data_we_way_mask_o != 4'h0) early_wr++;
    end
    @(negedge clk_i); mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1; mem_rsp_data_i = b0; #1;
    if (mem_req_valid_o) nv++;
    if (tag_we_way_mask_o != 4'h0 || data_we_way_mask_o != 4'h0) early_wr++;
    @(negedge clk_i); mem_rsp_data_i = b1; flush_i = do_flush; #1;
    if (tag_we_way_mask_o != 4'h0 || data_we_way_mask_o != 4'h0) early_wr++;
    check({nv_s(nm), "_recv_miss_ready"}, miss_ready_o, 0);
    @(negedge clk_i); mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0; flush_i = 1'b0; #1;
    check({nv_s(nm), "_req_valid_cycles"}, nv, dly + 1);
    check({nv_s(nm), "_early_write"}, early_wr, 0);
    check({nv_s(nm), "_tag_we"}, tag_we_way_mask_o, m);
    check({nv_s(nm), "_data_we"}, data_we_way_mask_o, m);
    check({nv_s(nm), "_bank_sel"}, tag_w_bank_sel_o, exp_bank);
    check({nv_s(nm), "_bank_addr"}, tag_w_bank_addr_o, exp_set);
    check({nv_s(nm), "_tag"}, tag_wdata_tag_o, exp_tag);
    check({nv_s(nm), "_valid"}, tag_wdata_valid_o, 1);
    check({nv_s(nm), "_data"}, data_wdata_o, {b1, b0});
    check({nv_s(nm), "_done"}, refill_done_o, 1);
    check({nv_s(nm), "_way"}, refill_way_o, w);
    check({nv_s(nm), "_wr_busy"}, flush_busy_o, 0);
    check({nv_s(nm), "_wr_miss_ready"}, miss_ready_o, 0);
    model_advance();
    @(negedge clk_i); #1;
    check({nv_s(nm), "_post_done"}, refill_done_o, 0);
    check({nv_s(nm), "_post_busy"}, flush_busy_o, do_flush);
    check({nv_s(nm), "_post_miss_ready"}, miss_ready_o, !do_flush);
  endtask

  function automatic string nv_s(input string s);
    return s;
  endfunction

  // Five-refill table: address, line base, bank, set, tag (hand-derived from the field split).
  logic [31:0] t_addr [5] = '{32'h0000_1000, 32'h0000_1014, 32'h0040_2028, 32'h0000_3FF0, 32'hC000_0000};
  logic [31:0] t_al   [5] = '{32'h0000_1000, 32'h0000_1010, 32'h0040_2020, 32'h0000_3FF0, 32'hC000_0000};
  logic [1:0]  t_bank [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0]  t_set  [5] = '{8'h40, 8'h40, 8'h80, 8'hFF, 8'h00};
  logic [17:0] t_tag  [5] = '{18'h0, 18'h0, 18'h00100, 18'h0, 18'h30000};

  initial begin
    int bad;
    int n;
    int n0;
    rst_i = 1'b1; miss_valid_i = 1'b0; miss_addr_i = '0; flush_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    spurious = 0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_busy", flush_busy_o, 1);
    check("rst_tag_we", tag_we_way_mask_o, 0);
    check("rst_miss_ready", miss_ready_o, 0);
    check("rst_req_valid", mem_req_valid_o, 0);
    check("rst_done", refill_done_o, 0);
    check("rst_data", data_wdata_o, 0);

    // Post-reset sweep: entry k written at sample k, 1024 entries
    @(negedge clk_i); rst_i = 1'b0; #1;
    bad = 0;
    for (int k = 0; k < 1024; k++) begin
      if (k > 0) begin
        @(negedge clk_i); #1;
      end
      if (!(flush_busy_o && tag_we_way_mask_o == 4'hF && !tag_wdata_valid_o &&
            tag_wdata_tag_o == 18'h0 && data_we_way_mask_o == 4'h0 &&
            tag_w_bank_sel_o == 2'(k % 4) && tag_w_bank_addr_o == 8'(k / 4) && !miss_ready_o))
        bad++;
      if (k == 5) begin
        check("sweep_k5_sel", tag_w_bank_sel_o, 2'd1);
        check("sweep_k5_addr", tag_w_bank_addr_o, 8'd1);
      end
    end
    check("sweep_entries_bad", bad, 0);
    @(negedge clk_i); #1;
    check("sweep_end_busy", flush_busy_o, 0);
    check("sweep_end_ready", miss_ready_o, 1);
    check("sweep_end_tag_we", tag_we_way_mask_o, 0);

    // Basic refill with hand-computed fields
    refill("r1", 32'h8000_1235, 32'h8000_1230, 2'd3, 8'h48, 18'h20000,
           64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 0, 1'b0);
    // Memory request held off for 5 cycles
    refill("r2", 32'h0000_0040, 32'h0000_0040, 2'd0, 8'h01, 18'h0,
           64'hA5A5_0000_FFFF_0001, 64'h5A5A_1234_0000_8765, 5, 1'b0);
    // Flush pulse during MEM_RECV: refill completes, sweep follows immediately
    refill("r3", 32'hFFFF_FFFC, 32'hFFFF_FFF0, 2'd3, 8'hFF, 18'h3FFFF,
           64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, 1'b1);
    spurious = 0;
    wait_sweep(n);
    check("pend_sweep_len", n, 1024);
    check("pend_sweep_spurious", spurious, 0);
    check("pend_sweep_ready", miss_ready_o, 1);

    // Reset one cycle after beat 0, then a stray beat 1
    @(negedge clk_i); miss_valid_i = 1'b1; miss_addr_i = 32'h1000_0008; #1;
    check("rr_miss_ready", miss_ready_o, 1);
    @(negedge clk_i); miss_valid_i = 1'b0; mem_req_ready_i = 1'b1; #1;
    check("rr_req_valid", mem_req_valid_o, 1);
    @(negedge clk_i); mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i = 64'hDEAD_BEEF_DEAD_BEEF; #1;
    @(negedge clk_i); mem_rsp_valid_i = 1'b0; rst_i = 1'b1; #1;
    check("rr_in_rst_done", refill_done_o, 0);
    check("rr_in_rst_data_we", data_we_way_mask_o, 0);
    check("rr_in_rst_busy", flush_busy_o, 1);
    @(negedge clk_i); rst_i = 1'b0; mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i = 64'hCAFE_F00D_CAFE_F00D; model_reset(); #1;
    check("rr_restart_busy", flush_busy_o, 1);
    check("rr_restart_entry", {tag_w_bank_addr_o, tag_w_bank_sel_o}, 10'd0);
    check("rr_restart_tag_we", tag_we_way_mask_o, 4'hF);
    check("rr_stray_done", refill_done_o, 0);
    check("rr_stray_data_we", data_we_way_mask_o, 0);
    @(negedge clk_i); mem_rsp_valid_i = 1'b0; #1;
    spurious = 0;
    wait_sweep(n);
    // Entry 0 was already observed above
    check("rr_sweep_len", n, 1023);
    check("rr_sweep_spurious", spurious, 0);

    // Five refills: victim sequence from the model
    for (int i = 0; i < 5; i++) begin
      refill($sformatf("seq%0d", i), t_addr[i], t_al[i], t_bank[i], t_set[i], t_tag[i],
             64'h1000_0000_0000_0000 + 64'(i), 64'h2000_0000_0000_0000 + 64'(i), i % 2, 1'b0);
    end

    // Flush beats a same-cycle miss; flush held during the sweep does not restart it
    @(negedge clk_i); flush_i = 1'b1; miss_valid_i = 1'b1; miss_addr_i = 32'h0000_2000; #1;
    check("prio_miss_ready", miss_ready_o, 0);
    @(negedge clk_i); miss_valid_i = 1'b0; #1;
    check("prio_busy", flush_busy_o, 1);
    check("prio_req_valid", mem_req_valid_o, 0);
    spurious = 0;
    n0 = 0;
    repeat (3) begin
      if (flush_busy_o) n0++;
      @(negedge clk_i); #1;
    end
    flush_i = 1'b0;
    wait_sweep(n);
    check("held_flush_len", n0 + n, 1024);
    check("held_flush_spurious", spurious, 0);
    check("held_flush_ready", miss_ready_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
